// File: rtl/mcif_arb_ctrl4.sv
// mcif_arb_ctrl4: sequential control stage for the 4-client round-robin
// memory-interface arbiter. It enables the downstream combinational
// arbiter in IDLE, captures the winner, and holds that grant for a whole
// burst. It counts beats against mem_ready, then releases the grant.
module mcif_arb_ctrl4 #(
    parameter int LEN_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*LEN_W-1:0] req_len,
    input  logic               mem_ready,
    input  logic [1:0]         nxt_arb_id,
    output logic [3:0]         arb_req,
    output logic               arb_en,
    output logic [1:0]         cur_arb_id,
    output logic [3:0]         gnt,
    output logic               gnt_vld,
    output logic [3:0]         gnt_ack,
    output logic [LEN_W-1:0]   beat_cnt,
    output logic               beat_last
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         curId_q, curId_d;
    logic [3:0]         gnt_q, gnt_d;
    logic               gntVld_q, gntVld_d;
    logic [3:0]         gntAck_q, gntAck_d;
    logic [LEN_W-1:0]   beatCnt_q, beatCnt_d;

    logic [LEN_W-1:0]   selLen;
    logic [3:0]         winOneHot;

    assign selLen    = req_len[nxt_arb_id*LEN_W +: LEN_W];
    assign winOneHot = 4'b0001 << nxt_arb_id;

    // Next-state logic: grant the comb arbiter's winner in IDLE, then count beats down in XFER
    always_comb begin
        state_d   = state_q;
        curId_d   = curId_q;
        gnt_d     = gnt_q;
        gntVld_d  = gntVld_q;
        gntAck_d  = gntAck_q;
        beatCnt_d = beatCnt_q;
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    curId_d   = nxt_arb_id;
                    gnt_d     = winOneHot;
                    gntAck_d  = winOneHot;
                    gntVld_d  = 1'b1;
                    beatCnt_d = selLen;
                    state_d   = XFER;
                end
            end
            XFER: begin
                gntAck_d = 4'b0000;
                if (mem_ready) begin
                    if (beatCnt_q != '0) begin
                        beatCnt_d = beatCnt_q - LEN_W'(1);
                    end else begin
                        gnt_d    = 4'b0000;
                        gntVld_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset leaves the pointer at 3 so client 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            curId_q   <= 2'd3;
            gnt_q     <= 4'b0000;
            gntVld_q  <= 1'b0;
            gntAck_q  <= 4'b0000;
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            curId_q   <= curId_d;
            gnt_q     <= gnt_d;
            gntVld_q  <= gntVld_d;
            gntAck_q  <= gntAck_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    assign arb_req    = req;
    assign arb_en     = (state_q == IDLE) && (req != 4'b0000);
    assign cur_arb_id = curId_q;
    assign gnt        = gnt_q;
    assign gnt_vld    = gntVld_q;
    assign gnt_ack    = gntAck_q;
    assign beat_cnt   = beatCnt_q;
    assign beat_last  = gntVld_q & mem_ready & (beatCnt_q == '0);

endmodule

// File: tb/tb_mcif_arb_ctrl4.sv
// tb_mcif_arb_ctrl4: directed bench for mcif_arb_ctrl4. It models the
// downstream round-robin comb arbiter to close the loop, and it keeps a
// cycle model of the controller that pushes expected register values
// into a scoreboard queue. Those values are popped after each edge.
module tb_mcif_arb_ctrl4;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] reqLen;
    logic        memReady;
    logic [1:0]  nxtArbId;
    logic [3:0]  arbReq;
    logic        arbEn;
    logic [1:0]  curArbId;
    logic [3:0]  gnt;
    logic        gntVld;
    logic [3:0]  gntAck;
    logic [3:0]  beatCnt;
    logic        beatLast;

    typedef struct packed {
        logic [3:0] gnt;
        logic       vld;
        logic [3:0] ack;
        logic [3:0] cnt;
        logic [1:0] id;
    } exp_t;

    exp_t sbQ[$];
    int   grantLog[$];

    int checks = 0;
    int errors = 0;

    logic       mXfer;
    logic [1:0] mId;
    logic [3:0] mGnt;
    logic       mVld;
    logic [3:0] mAck;
    logic [3:0] mCnt;

    logic [3:0] hitMask;
    int         gntHits;
    int         vldHits;
    int         lastHits;

    mcif_arb_ctrl4 #(.LEN_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_len    (reqLen),
        .mem_ready  (memReady),
        .nxt_arb_id (nxtArbId),
        .arb_req    (arbReq),
        .arb_en     (arbEn),
        .cur_arb_id (curArbId),
        .gnt        (gnt),
        .gnt_vld    (gntVld),
        .gnt_ack    (gntAck),
        .beat_cnt   (beatCnt),
        .beat_last  (beatLast)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Round-robin pick: the first requester after ptr wins, and ptr itself has lowest priority
    function automatic logic [1:0] rrPick(input logic [1:0] ptr, input logic [3:0] r);
        logic [1:0] c;
        rrPick = ptr;
        for (int k = 4; k >= 1; k--) begin
            c = ptr + 2'(k);
            if (r[c]) rrPick = c;
        end
    endfunction

    // Stand-in for mcif_arb_comb4: it arbitrates when enabled, otherwise it passes the pointer through
    assign nxtArbId = arbEn ? rrPick(curArbId, arbReq) : curArbId;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mXfer = 1'b0;
        mId   = 2'd3;
        mGnt  = 4'b0000;
        mVld  = 1'b0;
        mAck  = 4'b0000;
        mCnt  = 4'd0;
    endtask

    task automatic modelStep(input logic r, input logic [3:0] rq, input logic rdy);
        logic [1:0] pick;
        if (r) begin
            modelReset();
        end else if (!mXfer) begin
            if (rq != 4'b0000) begin
                pick  = rrPick(mId, rq);
                mId   = pick;
                mGnt  = 4'b0001 << pick;
                mAck  = 4'b0001 << pick;
                mVld  = 1'b1;
                mCnt  = reqLen[pick*4 +: 4];
                mXfer = 1'b1;
            end
        end else begin
            mAck = 4'b0000;
            if (rdy) begin
                if (mCnt != 4'd0) begin
                    mCnt = mCnt - 4'd1;
                end else begin
                    mGnt  = 4'b0000;
                    mVld  = 1'b0;
                    mXfer = 1'b0;
                end
            end
        end
    endtask

    task automatic clearStats(input logic [3:0] mask);
        hitMask  = mask;
        gntHits  = 0;
        vldHits  = 0;
        lastHits = 0;
        grantLog.delete();
    endtask

    // One clock cycle: drive inputs, check the combinational outputs, push the expectation, then pop and compare after the edge
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic rdy);
        exp_t e;
        rst      = r;
        req      = rq;
        memReady = rdy;
        #1;
        checkOutput("arb_req", 32'(arbReq), 32'(rq));
        checkOutput("arb_en", 32'(arbEn), 32'(!mXfer && (rq != 4'b0000)));
        checkOutput("beat_last", 32'(beatLast), 32'(mVld && rdy && (mCnt == 4'd0)));
        if (beatLast === 1'b1) lastHits++;
        modelStep(r, rq, rdy);
        sbQ.push_back('{gnt: mGnt, vld: mVld, ack: mAck, cnt: mCnt, id: mId});
        @(posedge clk);
        #1;
        e = sbQ.pop_front();
        checkOutput("gnt", 32'(gnt), 32'(e.gnt));
        checkOutput("gnt_vld", 32'(gntVld), 32'(e.vld));
        checkOutput("gnt_ack", 32'(gntAck), 32'(e.ack));
        checkOutput("beat_cnt", 32'(beatCnt), 32'(e.cnt));
        checkOutput("cur_arb_id", 32'(curArbId), 32'(e.id));
        if (gnt === hitMask) gntHits++;
        if (gntVld === 1'b1) vldHits++;
        for (int i = 0; i < 4; i++) begin
            if (gntAck[i] === 1'b1) grantLog.push_back(i);
        end
    endtask

    // Directed sequence that follows the test plan scenarios in order
    initial begin
        int expOrder[5];
        expOrder = '{0, 1, 2, 3, 0};
        rst      = 1'b1;
        req      = 4'b0000;
        reqLen   = 16'h0000;
        memReady = 1'b0;
        clearStats(4'b0000);
        @(posedge clk);
        #1;
        modelReset();

        $display("[TB] reset state");
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_vld", 32'(gntVld), 32'd0);
        checkOutput("rst_ack", 32'(gntAck), 32'd0);
        checkOutput("rst_cnt", 32'(beatCnt), 32'd0);
        checkOutput("rst_id", 32'(curArbId), 32'd3);

        $display("[TB] all clients requesting, single-beat bursts");
        clearStats(4'b0000);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("rr_count", 32'(grantLog.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < grantLog.size()) checkOutput("rr_order", 32'(grantLog[i]), 32'(expOrder[i]));
        end
        checkOutput("rr_vld_cycles", 32'(vldHits), 32'd5);
        applyStimulus(1'b0, 4'b0000, 1'b1);

        $display("[TB] client 2 four-beat burst");
        reqLen = 16'h0300;
        clearStats(4'b0100);
        applyStimulus(1'b0, 4'b0100, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("c2_gnt_cycles", 32'(gntHits), 32'd4);
        checkOutput("c2_ack_count", 32'(grantLog.size()), 32'd1);
        checkOutput("c2_last_count", 32'(lastHits), 32'd1);
        checkOutput("c2_ptr", 32'(curArbId), 32'd2);

        $display("[TB] two-beat burst with stalls");
        reqLen = 16'h0001;
        clearStats(4'b0001);
        applyStimulus(1'b0, 4'b0001, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("stall_xfer_cycles", 32'(vldHits), 32'd4);
        checkOutput("stall_last_count", 32'(lastHits), 32'd1);

        $display("[TB] committed burst with request changes");
        reqLen = 16'h0040;
        clearStats(4'b0010);
        applyStimulus(1'b0, 4'b0010, 1'b1);
        applyStimulus(1'b0, 4'b0010, 1'b1);
        reqLen = 16'h0090;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'b1000, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("commit_gnt_cycles", 32'(gntHits), 32'd5);
        checkOutput("commit_grants", 32'(grantLog.size()), 32'd2);
        if (grantLog.size() == 2) begin
            checkOutput("commit_first", 32'(grantLog[0]), 32'd1);
            checkOutput("commit_second", 32'(grantLog[1]), 32'd3);
        end

        $display("[TB] reset during a burst");
        reqLen = 16'h0007;
        clearStats(4'b0001);
        applyStimulus(1'b0, 4'b0001, 1'b1);
        applyStimulus(1'b0, 4'b0001, 1'b1);
        applyStimulus(1'b1, 4'b0001, 1'b1);
        checkOutput("midrst_gnt", 32'(gnt), 32'd0);
        checkOutput("midrst_cnt", 32'(beatCnt), 32'd0);
        checkOutput("midrst_id", 32'(curArbId), 32'd3);
        applyStimulus(1'b0, 4'b1001, 1'b1);
        checkOutput("postrst_ack", 32'(gntAck), 32'b0001);
        checkOutput("postrst_id", 32'(curArbId), 32'd0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 4'b0000, 1'b1);

        $display("[TB] maximum burst length");
        reqLen = 16'h0F00;
        clearStats(4'b0100);
        applyStimulus(1'b0, 4'b0100, 1'b1);
        for (int i = 0; i < 17; i++) applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("max_gnt_cycles", 32'(gntHits), 32'd16);
        checkOutput("max_last_count", 32'(lastHits), 32'd1);
        checkOutput("max_end_vld", 32'(gntVld), 32'd0);
        checkOutput("max_end_cnt", 32'(beatCnt), 32'd0);

        checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
